// File: rtl/alu_pkg.sv
// Shared constants, state encoding and the single-cycle ALU datapath for alu_seq_unit.
package alu_pkg;

  localparam int unsigned W         = 31;
  localparam int unsigned OP_W      = 3;
  localparam int unsigned MUL_CNT_W = $clog2(W + 1);

  localparam logic [OP_W-1:0] OP_NOT  = 3'b000;
  localparam logic [OP_W-1:0] OP_AND  = 3'b001;
  localparam logic [OP_W-1:0] OP_OR   = 3'b010;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b011;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b100;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b101;
  localparam logic [OP_W-1:0] OP_MUL  = 3'b110;
  localparam logic [OP_W-1:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [W:0] data;
    logic [W:0] hi;
    logic       err;
  } alu_res_t;

  // SUB reuses the adder as A + ~B + 1, so its carry-out means A >= B
  function automatic alu_res_t alu_single(input logic [OP_W-1:0] op,
                                          input logic [W:0]      a,
                                          input logic [W:0]      b);
    alu_res_t     res;
    logic [W:0]   b_eff;
    logic [W+1:0] sum;
    res   = '0;
    b_eff = (op == OP_SUB) ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{(W + 1){1'b0}}, (op == OP_SUB)};
    case (op)
      OP_NOT:         res.data = ~a;
      OP_AND:         res.data = a & b;
      OP_OR:          res.data = a | b;
      OP_XOR:         res.data = a ^ b;
      OP_ADD, OP_SUB: begin
        res.data = sum[W:0];
        res.hi   = {{W{1'b0}}, sum[W+1]};
      end
      default:        res.err = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_shift_add_mul.sv
// Shift-add unsigned multiplier: one step per cycle for W+1 cycles after start.
module alu_shift_add_mul
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W:0]       a,
  input  logic [W:0]       b,
  output logic             done,
  output logic [2*W+1:0]   product
);

  logic [W:0]           acc_q, acc_d;
  logic [W:0]           mplier_q, mplier_d;
  logic [W:0]           mcand_q, mcand_d;
  logic [MUL_CNT_W-1:0] cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic [W+1:0]         sum;
  logic [W:0]           step_acc;
  logic [W:0]           step_mplier;

  always_comb begin
    sum         = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    step_acc    = sum[W+1:1];
    step_mplier = {sum[0], mplier_q[W:1]};

    acc_d    = acc_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      acc_d    = '0;
      mplier_d = b;
      mcand_d  = a;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = step_acc;
      mplier_d = step_mplier;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == MUL_CNT_W'(W)) busy_d = 1'b0;
    end
  end

  // Product is taken from the final step's next-state so the caller can
  // register it on the same edge the last step completes.
  assign done    = busy_q && (cnt_q == MUL_CNT_W'(W));
  assign product = {step_acc, step_mplier};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Multi-cycle ALU sequencer: request/response handshakes around single-cycle ops and a shift-add MUL.
module alu_seq_unit
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OP_W-1:0] req_op,
  input  logic [W:0]      req_a,
  input  logic [W:0]      req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [W:0]      rsp_data,
  output logic [W:0]      rsp_hi,
  output logic            rsp_zero,
  output logic            rsp_err
);

  state_e         state_q, state_d;
  logic           ready_q, ready_d;
  logic           valid_q, valid_d;
  logic [W:0]     data_q, data_d;
  logic [W:0]     hi_q, hi_d;
  logic           zero_q, zero_d;
  logic           err_q, err_d;
  logic           mul_start;
  logic           mul_done;
  logic [2*W+1:0] mul_prod;
  alu_res_t       single;

  assign single = alu_single(req_op, req_a, req_b);

  alu_shift_add_mul u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (req_a),
    .b       (req_b),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    data_d    = data_q;
    hi_d      = hi_q;
    zero_d    = zero_q;
    err_d     = err_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          if (req_op == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_EXEC;
          end else begin
            data_d  = single.data;
            hi_d    = single.hi;
            zero_d  = (single.data == '0);
            err_d   = single.err;
            valid_d = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_EXEC: begin
        if (mul_done) begin
          data_d  = mul_prod[W:0];
          hi_d    = mul_prod[2*W+1:W+1];
          zero_d  = (mul_prod[W:0] == '0);
          err_d   = 1'b0;
          valid_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Registered ready keeps req_ready low through reset and for the first edge after it
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_data  = data_q;
  assign rsp_hi    = hi_q;
  assign rsp_zero  = zero_q;
  assign rsp_err   = err_q;

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

- Multi-cycle ALU sequencer.
- Accepts one operation request (opcode + two operands) over a valid/ready handshake and drives the ALU's gate-level datapath (NOT/AND/OR/XOR arrays, adder).
- Computes MUL with a shift-add loop and returns the result over a second valid/ready handshake.
- Sits between the CPU control/execute stage and the combinational ALU arrays; it is the requesting side that sequences and collects their outputs.

## Interface
- W, 31, MSB index; datapath is W+1 bits.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_op  in  3  opcode.
- req_a  in  W+1  operand A.
- req_b  in  W+1  operand B.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_data  out  W+1  result, low word.
- rsp_hi  out  W+1  MUL high word; ADD/SUB carry in bit 0; otherwise 0.
- rsp_zero  out  1  rsp_data == 0.
- rsp_err  out  1  reserved opcode.

## Operation
- Opcodes:
  - 000 NOT A; 001 A AND B; 010 A OR B; 011 A XOR B.
  - 100 A+B; 101 A-B, computed as A + NOT B + 1.
  - 110 unsigned MUL; 111 reserved.
- FSM states:
  - IDLE: req_ready=1. On req_valid: latch op/A/B; MUL → EXEC, else → DONE.
  - EXEC: iteration counter 0..W, one shift-add step per cycle. After step W → DONE.
  - DONE: rsp_valid=1. On rsp_ready → IDLE.
- Operands are sampled only at acceptance; later input changes are ignored.
- ADD/SUB:
  - Result is mod 2^(W+1).
  - rsp_hi[0] = carry-out of the W+1-bit add; for SUB, 1 means A ≥ B unsigned.
  - rsp_hi[W:1] = 0.
- MUL:
  - {rsp_hi, rsp_data} = full 2(W+1)-bit unsigned product.
  - Per step: if the multiplier LSB is 1, add the multiplicand into the upper accumulator half. Then shift the {carry, accumulator} right by one.
- Logic ops: rsp_hi = 0.
- Reserved opcode: rsp_err=1, rsp_data=0, rsp_hi=0, rsp_zero=1; same latency as logic ops.
- rsp_zero tests rsp_data only, for every op.

## Timing
- Reset (async, any state):
  - State → IDLE; MUL in flight is aborted, no response produced.
  - rsp_valid, rsp_data, rsp_hi, rsp_zero, rsp_err all 0.
  - req_ready=0 while rst high; 1 from the first clk edge after rst falls.
- Latency, counted from the acceptance edge to the rsp_valid rising edge:
  - Single-cycle ops: 1 cycle.
  - MUL: W+2 cycles (W+1 EXEC cycles + entry to DONE).
- Response outputs are registered. They must be stable while rsp_valid && !rsp_ready; backpressure is unbounded.
- No overlap: req_ready is 0 in EXEC and DONE.
  - After the rsp handshake edge, req_ready rises in the next cycle (IDLE).
  - Minimum request spacing: 2 cycles for single-cycle ops, W+3 for MUL.
- req_valid asserted outside IDLE is not accepted. The requester holds it; the unit takes no action.
- Response register and next request never collide: responses are not pipelined.

## Structure
- alu_pkg holds:
  - Opcode localparams (OP_NOT … OP_RSVD).
  - FSM state encoding (IDLE/EXEC/DONE).
  - 3-bit opcode width constant.
- Sub-module alu_shift_add_mul:
  - Accumulator, multiplier shift register and iteration counter.
  - Inputs: start, A, B. Outputs: done, product.
- alu_seq_unit owns the FSM, handshakes, logic/add paths and response registers.

## Test plan
- NOT (W=31): A=0x0000_FFFF, then rsp_ready=1.
  - rsp_data=0xFFFF_0000, rsp_hi=0, rsp_zero=0, rsp_valid exactly 1 cycle after acceptance.
- ADD/SUB:
  - 0xFFFF_FFFF+1 → rsp_data=0, rsp_hi=1, rsp_zero=1.
  - 5−7 → rsp_data=0xFFFF_FFFE, rsp_hi=0.
- MUL: 0xFFFF_FFFF × 0xFFFF_FFFF.
  - rsp_hi=0xFFFF_FFFE, rsp_data=0x0000_0001.
  - rsp_valid 33 cycles after acceptance; req_ready=0 throughout.
- Backpressure: hold rsp_ready=0 for 10 cycles after AND 0xF0F0_F0F0 & 0xFF00_FF00.
  - rsp_data=0xF000_F000 stable all 10 cycles; a new request held valid is not accepted until the cycle after the handshake.
- Reset mid-MUL: assert rst at EXEC iteration 15.
  - All outputs 0 immediately (async); no response after release.
  - Next request 3×4 returns 12.
- Reserved opcode 111: rsp_err=1, rsp_data=0, rsp_zero=1, latency 1.
